// File: rtl/ucj_pkg.sv
// Shared constants for the jump/branch control unit: condition codes and bit indices.
package ucj_pkg;

  localparam int unsigned COND_W   = 4;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned HOLD_BIT = 3;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 0;

  // Low three bits of cond; cond[HOLD_BIT] overrides all of these.
  typedef enum logic [2:0] {
    COND_NEXT = 3'd0,
    COND_JMP  = 3'd1,
    COND_JZ   = 3'd2,
    COND_JNZ  = 3'd3,
    COND_JC   = 3'd4,
    COND_JNC  = 3'd5,
    COND_JN   = 3'd6,
    COND_JNN  = 3'd7
  } cond_e;

endpackage

// File: rtl/ucj_if.sv
// Decoder/register-file/flag inputs and instruction-address output of the jump unit.
interface ucj_if
  import ucj_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) ();

  logic [COND_W-1:0] cond;
  logic [ADDR_W-1:0] Rx;
  logic [FLAG_W-1:0] F;
  logic [ADDR_W-1:0] o_Address_Instruction_Bus;

  modport master (
    output cond,
    output Rx,
    output F,
    input  o_Address_Instruction_Bus
  );

  modport slave (
    input  cond,
    input  Rx,
    input  F,
    output o_Address_Instruction_Bus
  );

endinterface

// File: rtl/ucj_cond_eval.sv
// Combinational jump-condition evaluator: decides whether the flag condition selects Rx.
module ucj_cond_eval
  import ucj_pkg::*;
(
  input  logic [2:0]        cond,
  input  logic [FLAG_W-1:0] F,
  output logic              taken
);

  // Decode the condition code against the current flags.
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_NEXT: taken = 1'b0;
      COND_JMP:  taken = 1'b1;
      COND_JZ:   taken = F[FLAG_Z];
      COND_JNZ:  taken = ~F[FLAG_Z];
      COND_JC:   taken = F[FLAG_C];
      COND_JNC:  taken = ~F[FLAG_C];
      COND_JN:   taken = F[FLAG_N];
      COND_JNN:  taken = ~F[FLAG_N];
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ucj.sv
// Jump/branch control unit: program counter with step, jump, and hold.
module ucj
  import ucj_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic  clk,
  input  logic  rst,
  ucj_if.slave  bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              taken;
  logic              hold;

  ucj_cond_eval u_cond_eval (
    .cond  (bus.cond[2:0]),
    .F     (bus.F),
    .taken (taken)
  );

  assign hold = bus.cond[HOLD_BIT];

  // Next-PC select: hold beats jump, jump beats sequential step (wraps modulo 2^ADDR_W).
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (hold) begin
      pc_next = pc;
    end else if (taken) begin
      pc_next = bus.Rx;
    end
  end

  // PC register; synchronous reset has priority over every condition code.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  assign bus.o_Address_Instruction_Bus = pc;

endmodule

// File: tb/tb_ucj.sv
// Directed self-checking bench for the jump/branch control unit.
module tb_ucj;

  localparam int unsigned ADDR_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ucj_if #(.ADDR_W(ADDR_W)) bus ();

  ucj #(.ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [ADDR_W-1:0] got,
                          input logic [ADDR_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, clock once, sample just after the rising edge.
  task automatic apply(input logic r, input logic [3:0] c, input logic [ADDR_W-1:0] rx,
                       input logic [2:0] f, input string tag,
                       input logic [ADDR_W-1:0] exp);
    @(negedge clk);
    rst      = r;
    bus.cond = c;
    bus.Rx   = rx;
    bus.F    = f;
    @(posedge clk);
    #1;
    check_eq(tag, bus.o_Address_Instruction_Bus, exp);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.cond = 4'b1000;
    bus.Rx   = 8'hF0;
    bus.F    = 3'b111;

    // Reset, including priority over HOLD and JMP
    apply(1'b1, 4'b1000, 8'hF0, 3'b111, "reset_hold", 8'h00);
    apply(1'b1, 4'b0001, 8'hF0, 3'b111, "reset_jmp",  8'h00);
    apply(1'b0, 4'b0000, 8'hF0, 3'b111, "release",    8'h01);

    // Unconditional and flag-true jumps
    apply(1'b0, 4'b0001, 8'hF0, 3'b111, "jmp",     8'hF0);
    apply(1'b0, 4'b0010, 8'hF0, 3'b111, "jz_t",    8'hF0);
    apply(1'b0, 4'b0100, 8'hF0, 3'b111, "jc_t",    8'hF0);
    apply(1'b0, 4'b0110, 8'hF0, 3'b111, "jn_t",    8'hF0);

    // Negated conditions not taken
    apply(1'b0, 4'b0011, 8'hF0, 3'b111, "jnz_nt",  8'hF1);
    apply(1'b0, 4'b0001, 8'hF0, 3'b111, "jmp_back",8'hF0);
    apply(1'b0, 4'b0101, 8'hF0, 3'b111, "jnc_nt",  8'hF1);

    // Per-flag independence: Z=0, C=1, N=1
    apply(1'b0, 4'b0001, 8'hF0, 3'b011, "jmp_f0",  8'hF0);
    apply(1'b0, 4'b0111, 8'hFA, 3'b011, "jnn_nt",  8'hF1);
    apply(1'b0, 4'b0011, 8'hFA, 3'b011, "jnz_t",   8'hFA);
    apply(1'b0, 4'b0010, 8'hFA, 3'b011, "jz_nt",   8'hFB);

    // Hold at 0xFF ignoring Rx and F, then wrap
    apply(1'b0, 4'b0001, 8'hFF, 3'b000, "jmp_ff",  8'hFF);
    apply(1'b0, 4'b1000, 8'h12, 3'b111, "hold1",   8'hFF);
    apply(1'b0, 4'b1001, 8'h34, 3'b000, "hold2",   8'hFF);
    apply(1'b0, 4'b1111, 8'h56, 3'b101, "hold3",   8'hFF);
    apply(1'b0, 4'b0000, 8'h56, 3'b101, "wrap",    8'h00);

    // Reset in the middle of a jump sequence
    apply(1'b0, 4'b0001, 8'h55, 3'b000, "jmp55_a", 8'h55);
    apply(1'b0, 4'b0001, 8'h55, 3'b000, "jmp55_b", 8'h55);
    apply(1'b1, 4'b0001, 8'h55, 3'b000, "mid_rst", 8'h00);
    apply(1'b0, 4'b0001, 8'h55, 3'b000, "jmp55_c", 8'h55);

    // Flags clear: positive conditions step, negated conditions jump
    apply(1'b0, 4'b0100, 8'h10, 3'b000, "jc_nt",   8'h56);
    apply(1'b0, 4'b0110, 8'h10, 3'b000, "jn_nt",   8'h57);
    apply(1'b0, 4'b0111, 8'h10, 3'b000, "jnn_t",   8'h10);
    apply(1'b0, 4'b0101, 8'h20, 3'b000, "jnc_t",   8'h20);
    apply(1'b0, 4'b0010, 8'h30, 3'b000, "jz_nt2",  8'h21);
    apply(1'b1, 4'b1000, 8'h30, 3'b000, "rst_hold",8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
